// File: rtl/fp_acc_seq.sv
// Streaming fp32 accumulator: sums a run of operands through an external
// combinational adder and presents the sum with a beat count and NaN/Inf flags.
module fp_acc_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_nan,
    output logic             out_inf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    logic [31:0]      acc;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             acc_exp_ones;

    // The adder sees the running sum and the current operand every cycle;
    // its result is only captured when a beat is actually accepted.
    assign add_a  = acc;
    assign add_b  = in_data;
    assign accept = in_valid & in_ready;

    assign out_data     = acc;
    assign out_count    = cnt;
    assign acc_exp_ones = (acc[30:23] == 8'hFF);
    assign out_nan      = acc_exp_ones & (acc[22:0] != 23'd0);
    assign out_inf      = acc_exp_ones & (acc[22:0] == 23'd0);

    // in_ready/out_valid are registered alongside the state so they change
    // exactly on state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= 32'h0000_0000;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (accept) begin
                        acc <= add_sum;
                        if (cnt != CNT_MAX)
                            cnt <= cnt + 1'b1;
                        if (in_last) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACC;
                        end
                    end else if (state == IDLE) begin
                        acc <= 32'h0000_0000;
                        cnt <= '0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        acc       <= 32'h0000_0000;
                        cnt       <= '0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    acc       <= 32'h0000_0000;
                    cnt       <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_acc_seq.sv
// Scoreboard bench for fp_acc_seq: directed sums with hand-computed results,
// behavioural fp32 adder on the add_a/add_b/add_sum loop.
module tb_fp_acc_seq;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [31:0]      add_sum;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_nan;
    logic             out_inf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0]      d;
        logic [CNT_W-1:0] c;
        logic             nan;
        logic             inf;
    } exp_t;

    exp_t exp_q[$];

    fp_acc_seq #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_nan   (out_nan),
        .out_inf   (out_inf)
    );

    always #5 clk = ~clk;

    // Behavioural external adder (denormals flushed, canonical quiet NaN).
    function automatic real sp2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'h00)
            d = {x[31], 63'd0};
        else if (x[30:23] == 8'hFF)
            d = {x[31], 11'h7FF, x[22:0], 29'd0};
        else
            d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        logic [10:0] eb;
        d = $realtobits(r);
        e = d[62:52];
        if (e == 11'h7FF)
            return (d[51:0] != 52'd0) ? 32'h7FC0_0000 : {d[63], 8'hFF, 23'd0};
        if (e == 11'd0)
            return {d[63], 31'd0};
        eb = e - 11'd896;
        return {d[63], eb[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
            return 32'h7FC0_0000;
        return r2sp(sp2r(a) + sp2r(b));
    endfunction

    always_comb add_sum = fadd(add_a, add_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input int c, input logic nan, input logic inf);
        exp_t e;
        e.d = d; e.c = CNT_W'(c); e.nan = nan; e.inf = inf;
        exp_q.push_back(e);
    endtask

    // Monitor: every output transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got data %h count %0d, expected no transfer",
                         out_data, out_count);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data",  out_data, e.d);
                check("out_count", 32'(out_count), 32'(e.c));
                check("out_nan",   32'(out_nan), 32'(e.nan));
                check("out_inf",   32'(out_inf), 32'(e.inf));
            end
        end
    end

    // Present one beat and hold it until accepted; returns 1 ns after the
    // accepting edge. Junk is driven on in_data/in_last afterwards.
    task automatic beat(input logic [31:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: in_ready never seen for %h", d);
        end
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        in_last  = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);

        // reset state
        check("rst_in_ready",  32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  out_data, 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);

        // 1 + 2 + 3 = 6, result one cycle after the last beat
        push_exp(32'h40C0_0000, 3, 1'b0, 1'b0);
        beat(32'h3F80_0000, 1'b0);
        beat(32'h4000_0000, 1'b0);
        beat(32'h4040_0000, 1'b1);
        check("lat_out_valid", 32'(out_valid), 32'd1);
        check("lat_in_ready",  32'(in_ready), 32'd0);
        idle(1);
        check("post_out_valid", 32'(out_valid), 32'd0);
        check("post_acc_clear", out_data, 32'd0);

        // single negative beat
        push_exp(32'hC0A0_0000, 1, 1'b0, 1'b0);
        beat(32'hC0A0_0000, 1'b1);
        idle(1);

        // +Inf + -Inf -> NaN
        push_exp(32'h7FC0_0000, 2, 1'b1, 1'b0);
        beat(32'h7F80_0000, 1'b0);
        beat(32'hFF80_0000, 1'b1);
        idle(1);

        // back-pressure in DONE: 2 + 3 = 5 held for 5 cycles
        out_ready = 1'b0;
        push_exp(32'h40A0_0000, 2, 1'b0, 1'b0);
        beat(32'h4000_0000, 1'b0);
        beat(32'h4040_0000, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'h3F80_0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready",  32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_data",  out_data, 32'h40A0_0000);
            check("stall_out_count", 32'(out_count), 32'd2);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(1);
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_acc_clear", out_data, 32'd0);
        check("release_cnt_clear", 32'(out_count), 32'd0);
        idle(1);

        // reset mid-sum: no result for the aborted sum
        beat(32'h3F80_0000, 1'b0);
        beat(32'h3F80_0000, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("abort_out_count", 32'(out_count), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        push_exp(32'h3F80_0000, 1, 1'b0, 1'b0);
        beat(32'h3F80_0000, 1'b1);
        idle(1);

        // ten ones with irregular gaps -> 10.0
        push_exp(32'h4120_0000, 10, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            idle(int'($urandom_range(0, 3)));
            beat(32'h3F80_0000, (i == 9) ? 1'b1 : 1'b0);
        end
        idle(4);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
